// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipelined RISC-V core hazard logic:
// forward-select encodings, hazard FSM state type and default register-address width.
package riscv_pipe_pkg;

  // Default register-address width (RV32I); RV32E builds use 4.
  localparam int DEF_REG_AW = 5;

  // Operand forward-select encodings driven to the Execute-stage muxes.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // Data-memory wait tracking FSM.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } hz_state_e;

  // Even parity over a forward-select code, used by integrity checkers.
  function automatic logic fwd_parity(input logic [1:0] sel);
    return ^sel;
  endfunction

endpackage

// File: rtl/riscv_fwd_sel.sv
// Forwarding selector for one Execute-stage source operand.
// Memory-stage result beats Writeback-stage result; x0 is never forwarded.
module riscv_fwd_sel
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  logic hit_m_s;
  logic hit_w_s;

  assign hit_m_s = reg_write_m_i && (rd_m_i == rs_e_i) && (rd_m_i != {REG_AW{1'b0}});
  assign hit_w_s = reg_write_w_i && (rd_w_i == rs_e_i) && (rd_w_i != {REG_AW{1'b0}});

  // Pick the youngest producer of the operand, falling back to the register file.
  always_comb begin
    fwd_o = FWD_REG;
    if (hit_m_s) begin
      fwd_o = FWD_M;
    end else if (hit_w_s) begin
      fwd_o = FWD_W;
    end else begin
      fwd_o = FWD_REG;
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl_mc.sv
// Hazard controller for the 5-stage pipelined core with variable-latency
// instruction/data memories. Drives operand forwarding, per-stage stall and
// flush enables, wrong-path fetch kill and a sticky data-wait timeout flag.
// Optional macro HAZARD_PERF_CNT_EN adds free-running performance counters.
module riscv_hazard_ctrl_mc
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic [REG_AW-1:0] rd_E,
  input  logic [REG_AW-1:0] rd_M,
  input  logic [REG_AW-1:0] rd_W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MemAccessM,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Stall_M,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_W,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]  perf_lu_stall,
  output logic [CNT_W-1:0]  perf_dwait,
  output logic [CNT_W-1:0]  perf_flush,
`endif
  output logic              mem_timeout_err
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_ONE = {{(WCW-1){1'b0}}, 1'b1};

  // Registered state.
  hz_state_e      state_q,    state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           kill_q,     kill_d;
  logic           err_q,      err_d;

  // Raw hazard conditions.
  logic lw_stall_s;
  logic mem_wait_s;
  logic fetch_wait_s;

  // One-hot winner of the priority chain (all low during reset).
  logic sel_mem_s;
  logic sel_redir_s;
  logic sel_lu_s;
  logic sel_fetch_s;

  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i        (rs1_E),
    .rd_m_i        (rd_M),
    .rd_w_i        (rd_W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_a_s)
  );

  riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i        (rs2_E),
    .rd_m_i        (rd_M),
    .rd_w_i        (rd_W),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_b_s)
  );

  assign lw_stall_s   = ResultSrcE0 && (rd_E != {REG_AW{1'b0}}) &&
                        ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign mem_wait_s   = MemAccessM && !dmem_ready;
  assign fetch_wait_s = !imem_ready || kill_q;

  // A data wait freezes everything, including a resolved branch in Execute,
  // which redirects only once the wait has ended.
  assign sel_mem_s   = !reset && mem_wait_s;
  assign sel_redir_s = !reset && !mem_wait_s && PCSrcE;
  assign sel_lu_s    = !reset && !mem_wait_s && !PCSrcE && lw_stall_s;
  assign sel_fetch_s = !reset && !mem_wait_s && !PCSrcE && !lw_stall_s && fetch_wait_s;

  // Forward selects are forced to the register file while in reset.
  always_comb begin
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (reset) begin
      ForwardAE = FWD_REG;
      ForwardBE = FWD_REG;
    end else begin
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end
  end

  // Stall/flush enables from the priority chain.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_W = 1'b0;
    if (reset) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
      Flush_W = 1'b1;
    end else if (sel_mem_s) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (sel_redir_s) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (sel_lu_s) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end else if (sel_fetch_s) begin
      // A pending kill with data valid drops that wrong-path response
      // into a bubble while letting the fetch stage move on.
      Stall_F = !imem_ready;
      Flush_D = 1'b1;
    end else begin
      Stall_F = 1'b0;
      Flush_D = 1'b0;
    end
  end

  // Wrong-path kill flag: armed by a redirect that cannot be served this
  // cycle, cleared when the stale response finally arrives.
  always_comb begin
    kill_d = kill_q;
    if (sel_redir_s && (!imem_ready || kill_q)) begin
      kill_d = 1'b1;
    end else if (imem_ready) begin
      kill_d = 1'b0;
    end else begin
      kill_d = kill_q;
    end
  end

  // Data-wait FSM with saturating wait counter and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      RUN: begin
        if (mem_wait_s) begin
          state_d    = DWAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          state_d    = RUN;
          wait_cnt_d = {WCW{1'b0}};
        end
      end
      DWAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = {WCW{1'b0}};
        end else if (mem_wait_s && (wait_cnt_q < WAIT_MAX)) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = {WCW{1'b0}};
      end
    endcase
    if (wait_cnt_d == WAIT_MAX) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous reset; reset aborts any wait in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= {WCW{1'b0}};
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_lu_q;
  logic [CNT_W-1:0] perf_dwait_q;
  logic [CNT_W-1:0] perf_flush_q;

  // Event counters wrap naturally and are frozen to zero during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lu_q    <= {CNT_W{1'b0}};
      perf_dwait_q <= {CNT_W{1'b0}};
      perf_flush_q <= {CNT_W{1'b0}};
    end else begin
      perf_lu_q    <= perf_lu_q    + {{(CNT_W-1){1'b0}}, sel_lu_s};
      perf_dwait_q <= perf_dwait_q + {{(CNT_W-1){1'b0}}, sel_mem_s};
      perf_flush_q <= perf_flush_q + {{(CNT_W-1){1'b0}}, sel_redir_s};
    end
  end

  assign perf_lu_stall = perf_lu_q;
  assign perf_dwait    = perf_dwait_q;
  assign perf_flush    = perf_flush_q;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl_mc.sv
// Directed self-checking bench for riscv_hazard_ctrl_mc (default parameters).
module tb_riscv_hazard_ctrl_mc;
  import riscv_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM;
  logic       dmem_ready, imem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
  logic       mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stall, perf_dwait, perf_flush;
`endif

  int vectors = 0;
  int miscompares = 0;

  // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
  logic [6:0] ctl;
  assign ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W};

  riscv_hazard_ctrl_mc dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
`ifdef HAZARD_PERF_CNT_EN
    .perf_lu_stall(perf_lu_stall), .perf_dwait(perf_dwait), .perf_flush(perf_flush),
`endif
    .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle: inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Outputs are observed on the falling edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1_D = 5'd0; rs2_D = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
    rd_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
    PCSrcE = 1'b0; MemAccessM = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  initial begin
    // Reset with forwarding conditions present: forwards must still be 00.
    idle_inputs();
    reset = 1'b1;
    rd_M = 5'd5; RegWriteM = 1'b1; rs1_E = 5'd5;
    #1;
    settle();
    chk("reset_ctl", 32'(ctl), 32'(7'b0000_111));
    chk("reset_fwdA", 32'(ForwardAE), 32'(2'b00));
    next_cycle();
    reset = 1'b0;
    idle_inputs();

    // Forwarding priority.
    rd_M = 5'd5; rd_W = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; rs1_E = 5'd5;
    settle();
    chk("fwd_m_prio", 32'(ForwardAE), 32'(2'b10));
    chk("run_ctl", 32'(ctl), 32'(7'b0000_000));
    next_cycle();
    RegWriteM = 1'b0;
    settle();
    chk("fwd_w", 32'(ForwardAE), 32'(2'b01));
    next_cycle();
    rs1_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0; RegWriteM = 1'b1; RegWriteW = 1'b1;
    settle();
    chk("fwd_x0", 32'(ForwardAE), 32'(2'b00));
    next_cycle();
    rs2_E = 5'd7; rd_M = 5'd7; rd_W = 5'd9;
    settle();
    chk("fwd_b_m", 32'(ForwardBE), 32'(2'b10));
    chk("fwd_a_none", 32'(ForwardAE), 32'(2'b00));
    next_cycle();
    idle_inputs();

    // Load-use: one bubble, then the loader leaves Execute.
    ResultSrcE0 = 1'b1; rd_E = 5'd3; rs2_D = 5'd3;
    settle();
    chk("lu_stall", 32'(ctl), 32'(7'b1100_010));
    next_cycle();
    ResultSrcE0 = 1'b0; rd_E = 5'd0;
    settle();
    chk("lu_release", 32'(ctl), 32'(7'b0000_000));
    next_cycle();
    ResultSrcE0 = 1'b1; rd_E = 5'd0; rs1_D = 5'd0; rs2_D = 5'd0;
    settle();
    chk("lu_x0", 32'(ctl), 32'(7'b0000_000));
    next_cycle();
    idle_inputs();

    // Data wait of 3 cycles.
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk("dwait_ctl", 32'(ctl), 32'(7'b1111_001));
      next_cycle();
    end
    chk("dwait_state", 32'(dut.state_q), 32'(DWAIT));
    dmem_ready = 1'b1;
    settle();
    chk("dwait_done_ctl", 32'(ctl), 32'(7'b0000_000));
    chk("dwait_no_err", 32'(mem_timeout_err), 32'(1'b0));
    next_cycle();
    MemAccessM = 1'b0;
    settle();
    chk("dwait_run", 32'(dut.state_q), 32'(RUN));
    chk("dwait_cnt0", 32'(dut.wait_cnt_q), 32'd0);
    next_cycle();

    // Data wait overrides a taken branch until memory completes.
    MemAccessM = 1'b1; dmem_ready = 1'b0; PCSrcE = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      settle();
      chk("dwait_br_ctl", 32'(ctl), 32'(7'b1111_001));
      next_cycle();
    end
    dmem_ready = 1'b1;
    settle();
    chk("dwait_br_redir", 32'(ctl), 32'(7'b0000_110));
    next_cycle();
    idle_inputs();

    // Timeout after 16 consecutive wait cycles.
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      settle();
      chk("tmo_ctl", 32'(ctl), 32'(7'b1111_001));
      if (i == 15) chk("tmo_not_yet", 32'(mem_timeout_err), 32'(1'b0));
      next_cycle();
    end
    dmem_ready = 1'b1;
    settle();
    chk("tmo_set", 32'(mem_timeout_err), 32'(1'b1));
    chk("tmo_ready_ctl", 32'(ctl), 32'(7'b0000_000));
    next_cycle();
    MemAccessM = 1'b0;
    settle();
    chk("tmo_sticky", 32'(mem_timeout_err), 32'(1'b1));
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    settle();
    chk("tmo_cleared", 32'(mem_timeout_err), 32'(1'b0));
    next_cycle();

    // Wrong-path kill.
    PCSrcE = 1'b1; imem_ready = 1'b0;
    settle();
    chk("kill_redir", 32'(ctl), 32'(7'b0000_110));
    next_cycle();
    PCSrcE = 1'b0;
    settle();
    chk("kill_armed", 32'(dut.kill_q), 32'(1'b1));
    chk("kill_wait_ctl", 32'(ctl), 32'(7'b1000_100));
    next_cycle();
    imem_ready = 1'b1;
    settle();
    chk("kill_drop_ctl", 32'(ctl), 32'(7'b0000_100));
    next_cycle();
    settle();
    chk("kill_cleared", 32'(dut.kill_q), 32'(1'b0));
    chk("kill_pass_ctl", 32'(ctl), 32'(7'b0000_000));
    next_cycle();

    // Second redirect while kill is pending keeps it set.
    PCSrcE = 1'b1; imem_ready = 1'b0;
    next_cycle();
    imem_ready = 1'b1;
    settle();
    chk("kill2_redir_ctl", 32'(ctl), 32'(7'b0000_110));
    next_cycle();
    PCSrcE = 1'b0;
    settle();
    chk("kill2_held", 32'(dut.kill_q), 32'(1'b1));
    chk("kill2_drop_ctl", 32'(ctl), 32'(7'b0000_100));
    next_cycle();
    settle();
    chk("kill2_pass_ctl", 32'(ctl), 32'(7'b0000_000));
    next_cycle();

    // Reset in the middle of a data wait.
    MemAccessM = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) next_cycle();
    chk("mid_cnt5", 32'(dut.wait_cnt_q), 32'd5);
    reset = 1'b1;
    settle();
    chk("mid_reset_ctl", 32'(ctl), 32'(7'b0000_111));
    next_cycle();
    reset = 1'b0;
    MemAccessM = 1'b0; dmem_ready = 1'b1;
    settle();
    chk("mid_state_run", 32'(dut.state_q), 32'(RUN));
    chk("mid_cnt0", 32'(dut.wait_cnt_q), 32'd0);
    chk("mid_ctl", 32'(ctl), 32'(7'b0000_000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
